fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Instruction queue between the PC/instruction-memory fetch stage and the decode stage of the 5-stage RV32I pipeline.
- Captures each fetched {PC, PC+4, instruction} triple and presents it to decode through a valid/ready handshake.
- Applies back-pressure to the PC stage when full and discards all queued entries on a flush (mispredict/JALR redirect).

Parameters:
- size, 32, data/address width in bits.
- DEPTH, 4, number of entries; a power of two, minimum 2.
- NOP, 32'h00000013, instruction word driven on out_instr when the buffer is empty (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discards all entries and any same-cycle push (mispredict/JALR redirect).
- in_valid  input  1  fetch stage presents a valid triple this cycle.
- in_ready  output  1  buffer accepts a push this cycle; equals !full.
- in_pc  input  size  PC_Addr of the fetched instruction.
- in_pc_save  input  size  PC_save (PC+4) of the same instruction.
- in_instr  input  size  instruction word from instruction memory.
- out_valid  output  1  head entry valid; equals !empty.
- out_ready  input  1  decode consumes the head this cycle.
- out_pc  output  size  head PC; 0 when empty.
- out_pc_save  output  size  head PC+4; 0 when empty.
- out_instr  output  size  head instruction; NOP when empty.
- count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Storage: circular buffer of DEPTH entries. Read pointer, write pointer and count are all registered.
- Reset (synchronous): pointers and count go to 0; out_valid=0, in_ready=1, out_pc=0, out_pc_save=0, out_instr=NOP. The storage array is not cleared.
- push = in_valid & in_ready & !flush. Writes the triple at the write pointer; the write pointer advances by 1 modulo DEPTH.
- pop = out_valid & out_ready & !flush. The read pointer advances by 1 modulo DEPTH.
- Pointer wrap: DEPTH is a power of two, so pointer wrap is natural overflow of the pointer bits. Full and empty are derived from count.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Latency: a triple pushed at edge N is visible on out_* after edge N. There is no combinational in→out bypass.
- Outputs: out_* are combinational reads at the read pointer, masked to 0/NOP when empty.
- Full: in_ready=0. A push attempt is ignored, with no state change, even if a pop occurs in the same cycle; in_ready depends on registered count only.
- Empty: out_valid=0. out_ready is ignored.
- Flush:
  - At the next edge, pointers and count go to 0.
  - A same-cycle push is dropped and a same-cycle pop is not counted.
  - The cycle after a flush is identical to the post-reset state.
- Priority: reset > flush > push/pop.
- Reset asserted mid-stream: same result as flush. Queued entries are lost; no partial state remains.
- Protocol: in_* values with in_valid=0 are don't-care. The producer holds its triple until in_ready; the buffer never overwrites an unread entry.

Decomposition:
- Shared package holds:
  - The NOP constant 32'h00000013.
  - The instruction/address width (size=32).
  - A fetch-entry struct {pc, pc_save, instr}, shared with the IF/ID register and decode.
- One natural sub-module: fetch_buffer_ptr, the modulo-DEPTH pointer/counter pair with inc/clr. Instantiate it twice (read, write), or use it for count with up/down enable.
- Storage array and output muxing stay in the top module.

Test Plan:
1. Reset then idle: hold reset 2 cycles, release. Required: out_valid=0, out_instr=32'h00000013, count=0, in_ready=1.
2. Fill and block:
   - Push PC=0/4/8/12 (pc_save +4, instr=PC|32'h100) with out_ready=0. Required: count=4, in_ready=0.
   - A 5th push with PC=16 is ignored. Required: head remains PC=0.
3. Drain in order: from full, out_ready=1 for 4 cycles. Required: out_pc sequence 0,4,8,12, then out_valid=0 and count=0.
4. Wrap and simultaneous push/pop:
   - Push 6 entries while popping continuously from cycle 2.
   - Required: count stays at 1 during overlap; PCs exit in order across pointer wrap (entries 5–6 reuse slots 0–1).
5. Flush:
   - With 3 entries queued, assert flush together with in_valid=1 (PC=100) and out_ready=1.
   - Required next cycle: count=0, out_valid=0; PC=100 never appears.
   - A following push of PC=200 appears at out_pc one cycle later.
6. Reset mid-operation: with 2 entries queued, assert reset for 1 cycle. Required next cycle: count=0, in_ready=1, out_instr=NOP.

Source files
------------

// File: rtl/fetch_buffer_pkg.sv
// Shared fetch-stage definitions: instruction width, NOP word, fetch-entry layout.
package fetch_buffer_pkg;

    localparam int unsigned SIZE = 32;

    // addi x0,x0,0
    localparam logic [SIZE-1:0] NOP_INSTR = 32'h00000013;

    // One fetched instruction as seen by the IF/ID register and decode.
    typedef struct packed {
        logic [SIZE-1:0] pc;
        logic [SIZE-1:0] pc_save;
        logic [SIZE-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_ptr.sv
// Modulo-2^WIDTH pointer with synchronous clear and increment.
module fetch_buffer_ptr #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    // Pointer register; wrap is natural overflow of the pointer bits.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            value <= '0;
        end else if (inc) begin
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode: circular buffer with
// valid/ready handshakes, full back-pressure and flush on redirect.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int unsigned     size  = SIZE,
    parameter int unsigned     DEPTH = 4,
    parameter logic [size-1:0] NOP   = NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [size-1:0]          in_pc,
    input  logic [size-1:0]          in_pc_save,
    input  logic [size-1:0]          in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [size-1:0]          out_pc,
    output logic [size-1:0]          out_pc_save,
    output logic [size-1:0]          out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [size-1:0] mem_pc      [DEPTH];
    logic [size-1:0] mem_pc_save [DEPTH];
    logic [size-1:0] mem_instr   [DEPTH];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Handshake qualifiers derived from registered count only.
    always_comb begin
        full      = (count == FULL_CNT);
        empty     = (count == '0);
        in_ready  = !full;
        out_valid = !empty;
        push      = in_valid && in_ready && !flush;
        pop       = out_valid && out_ready && !flush;
    end

    fetch_buffer_ptr #(.WIDTH(AW)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (pop),
        .value (rd_ptr)
    );

    fetch_buffer_ptr #(.WIDTH(AW)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .inc   (push),
        .value (wr_ptr)
    );

    // Occupancy counter; push and pop together leave it unchanged.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CW'(1);
        end else if (pop && !push) begin
            count <= count - CW'(1);
        end
    end

    // Storage write; the array is deliberately not cleared on reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]      <= in_pc;
            mem_pc_save[wr_ptr] <= in_pc_save;
            mem_instr[wr_ptr]   <= in_instr;
        end
    end

    // Head read, masked to zero/NOP while empty.
    always_comb begin
        out_pc      = '0;
        out_pc_save = '0;
        out_instr   = NOP;
        if (!empty) begin
            out_pc      = mem_pc[rd_ptr];
            out_pc_save = mem_pc_save[rd_ptr];
            out_instr   = mem_instr[rd_ptr];
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer.
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_pc_save;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc_save;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [31:0] NOP_WORD = 32'h00000013;

    fetch_buffer #(.size(32), .DEPTH(4), .NOP(32'h00000013)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_pc_save  (in_pc_save),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_pc_save (out_pc_save),
        .out_instr   (out_instr),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; sample/drive 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc);
        in_valid   = v;
        in_pc      = pc;
        in_pc_save = pc + 32'd4;
        in_instr   = pc | 32'h100;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 32'h0);

        // 1. reset then idle
        repeat (2) step();
        reset = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, NOP_WORD);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // empty buffer ignores out_ready
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("empty_pop_count", 32'(count), 32'd0);

        // 2. fill and block
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'(4 * i));
            step();
        end
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head_instr", out_instr, 32'h100);
        set_in(1'b1, 32'd16);
        step();
        set_in(1'b0, 32'h0);
        check("blocked_count", 32'(count), 32'd4);
        check("blocked_head_pc", out_pc, 32'd0);

        // 3. drain in order
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", out_pc, 32'(4 * i));
            check("drain_pc_save", out_pc_save, 32'(4 * i + 4));
            step();
        end
        out_ready = 1'b0;
        check("drained_valid", 32'(out_valid), 32'd0);
        check("drained_count", 32'(count), 32'd0);

        // 4. wrap with simultaneous push/pop
        set_in(1'b1, 32'h40);
        step();
        check("ovl_first_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        for (int k = 1; k < 6; k++) begin
            set_in(1'b1, 32'(32'h40 + 4 * k));
            check("ovl_pc", out_pc, 32'(32'h40 + 4 * (k - 1)));
            step();
            check("ovl_count", 32'(count), 32'd1);
        end
        set_in(1'b0, 32'h0);
        check("ovl_last_pc", out_pc, 32'h54);
        check("ovl_last_instr", out_instr, 32'h154);
        step();
        out_ready = 1'b0;
        check("ovl_end_count", 32'(count), 32'd0);

        // 5. flush with same-cycle push and pop
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'(32'h80 + 4 * i));
            step();
        end
        check("preflush_count", 32'(count), 32'd3);
        flush = 1'b1;
        out_ready = 1'b1;
        set_in(1'b1, 32'd100);
        step();
        flush = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 32'h0);
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_instr", out_instr, NOP_WORD);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        set_in(1'b1, 32'd200);
        step();
        set_in(1'b0, 32'h0);
        check("postflush_pc", out_pc, 32'd200);
        check("postflush_count", 32'(count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("postflush_drain", 32'(count), 32'd0);

        // 6. reset mid-operation
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 32'(32'h200 + 4 * i));
            step();
        end
        set_in(1'b0, 32'h0);
        check("prereset_count", 32'(count), 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_instr", out_instr, NOP_WORD);
        check("midrst_valid", 32'(out_valid), 32'd0);
        set_in(1'b1, 32'h300);
        step();
        set_in(1'b0, 32'h0);
        check("postrst_pc", out_pc, 32'h300);
        check("postrst_pc_save", out_pc_save, 32'h304);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
